// File: rtl/dnn_accel_system_cpu_debug_ocimem_if.sv
// Avalon-MM slave bus through which the CPU reaches the debug on-chip RAM.
interface dnn_accel_system_cpu_debug_ocimem_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/dnn_accel_system_cpu_debug_ocimem.sv
// Debug on-chip memory: executes decoded JTAG read/write commands on a
// private RAM and shares that RAM with the CPU over an Avalon-MM slave.
module dnn_accel_system_cpu_debug_ocimem #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  dnn_accel_system_cpu_debug_ocimem_if.slave avs
);

  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_JRD, S_JCAP, S_JWR, S_CRD, S_CCAP, S_CDONE, S_CWR
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_mon_a;
  logic [31:0]       r_mon_d;
  logic              r_ready;
  logic              r_error;
  logic [31:0]       r_jdata;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic [31:0]       r_cpu_wdata;
  logic [31:0]       r_readdata;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [DEPTH];

  logic              w_waitreq;
  logic              w_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [31:0]       w_ram_wdata;
  logic              w_any_pulse;
  logic              w_mon_ok;
  logic              w_cpu_ok;
  logic              w_ram_ok;
  logic              w_jdo_addr_ok;
  logic              w_unused;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < LP_DEPTH;
  endfunction

  assign w_any_pulse   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign w_mon_ok      = in_range(r_mon_a);
  assign w_cpu_ok      = in_range(r_cpu_addr);
  assign w_ram_ok      = in_range(w_ram_addr);
  assign w_jdo_addr_ok = in_range(jdo[17 +: ADDR_W]);
  assign w_unused      = ^{jdo[37:36], jdo[2:0]};

  assign MonDReg             = r_mon_d;
  assign monitor_ready       = r_ready;
  assign monitor_error       = r_error;
  assign avs.avs_readdata    = r_readdata;
  assign avs.avs_waitrequest = w_waitreq;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state, RAM port steering and bus stall; JTAG outranks the CPU in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_waitreq   = 1'b1;
    w_we        = 1'b0;
    w_ram_addr  = r_mon_a;
    w_ram_wdata = r_jdata;
    case (r_state)
      S_IDLE: begin
        if (take_action_ocimem_b)         w_state_nxt = S_JWR;
        else if (take_action_ocimem_a)    w_state_nxt = jdo[35] ? S_JRD : S_IDLE;
        else if (take_no_action_ocimem_a) w_state_nxt = S_JRD;
        else if (avs.avs_read)            w_state_nxt = S_CRD;
        else if (avs.avs_write)           w_state_nxt = S_CWR;
      end
      S_JRD:  w_state_nxt = S_JCAP;
      S_JCAP: w_state_nxt = S_IDLE;
      S_JWR: begin
        w_we        = w_mon_ok;
        w_state_nxt = S_IDLE;
      end
      S_CRD: begin
        w_ram_addr  = r_cpu_addr;
        w_state_nxt = S_CCAP;
      end
      S_CCAP: w_state_nxt = S_CDONE;
      S_CDONE: begin
        w_waitreq   = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_CWR: begin
        w_waitreq   = 1'b0;
        w_ram_addr  = r_cpu_addr;
        w_ram_wdata = r_cpu_wdata;
        w_we        = w_cpu_ok;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Command capture, monitor registers and CPU read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mon_a     <= '0;
      r_mon_d     <= '0;
      r_ready     <= 1'b1;
      r_error     <= 1'b0;
      r_jdata     <= '0;
      r_cpu_addr  <= '0;
      r_cpu_wdata <= '0;
      r_readdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (take_action_ocimem_b) begin
            r_ready <= 1'b0;
            r_jdata <= jdo[34:3];
            if (take_action_ocimem_a | take_no_action_ocimem_a) r_error <= 1'b1;
          end else if (take_action_ocimem_a) begin
            r_mon_a <= jdo[17 +: ADDR_W];
            r_error <= take_no_action_ocimem_a | ~w_jdo_addr_ok;
            if (jdo[35]) r_ready <= 1'b0;
          end else if (take_no_action_ocimem_a) begin
            r_ready <= 1'b0;
          end else if (avs.avs_read | avs.avs_write) begin
            r_cpu_addr  <= avs.avs_address;
            r_cpu_wdata <= avs.avs_writedata;
          end
        end
        S_JWR: begin
          if (!w_mon_ok) r_error <= 1'b1;
          r_mon_a <= r_mon_a + 1'b1;
          r_ready <= 1'b1;
        end
        S_JCAP: begin
          r_mon_d <= w_mon_ok ? r_rdata : '0;
          if (!w_mon_ok) r_error <= 1'b1;
          r_mon_a <= r_mon_a + 1'b1;
          r_ready <= 1'b1;
        end
        S_CCAP: r_readdata <= w_cpu_ok ? r_rdata : '0;
        default: ;
      endcase
      // Pulses arriving mid-operation are dropped; this overrides the case above.
      if (r_state != S_IDLE && w_any_pulse) r_error <= 1'b1;
    end
  end

  // Single-port RAM, write on the edge, registered read; contents not reset.
  always_ff @(posedge clk) begin
    if (w_we)     r_mem[w_ram_addr[IDX_W-1:0]] <= w_ram_wdata;
    if (w_ram_ok) r_rdata <= r_mem[w_ram_addr[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_dnn_accel_system_cpu_debug_ocimem.sv
// Directed bench for the debug on-chip memory (DEPTH=200, ADDR_W=8).
module tb_dnn_accel_system_cpu_debug_ocimem;

  logic        clk = 1'b0;
  logic        reset;
  logic [37:0] jdo;
  logic        pa, pna, pb;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error;
  int          total = 0;
  int          bad   = 0;

  dnn_accel_system_cpu_debug_ocimem_if #(.ADDR_W(8)) u_if ();

  dnn_accel_system_cpu_debug_ocimem #(.ADDR_W(8), .DEPTH(200)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (pa),
    .take_no_action_ocimem_a (pna),
    .take_action_ocimem_b    (pb),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .avs                     (u_if.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic [7:0] addr);
    logic [37:0] v;
    v = '0;
    v[35] = rd;
    v[24:17] = addr;
    return v;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] data);
    logic [37:0] v;
    v = '0;
    v[34:3] = data;
    return v;
  endfunction

  // kind: 0 = ocimem_a, 1 = no_action_a, 2 = ocimem_b; returns 1 after the accept edge
  task automatic pulse(input int kind, input logic [37:0] v);
    jdo = v;
    pa  = (kind == 0);
    pna = (kind == 1);
    pb  = (kind == 2);
    step();
    pa = 1'b0; pna = 1'b0; pb = 1'b0;
  endtask

  // Avalon transfer; cycles = edges until waitrequest seen low (capped at 20)
  task automatic cpu_xfer(input logic rd, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, output int cycles, output logic [31:0] rdata);
    u_if.avs_address = addr; u_if.avs_writedata = wdata;
    u_if.avs_read = rd; u_if.avs_write = wr;
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (u_if.avs_waitrequest && cycles < 20);
    rdata = u_if.avs_readdata;
    step();
    u_if.avs_read = 1'b0; u_if.avs_write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL reset_mondreg got=%h exp=0", MonDReg); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b exp=0", monitor_error); end
    total++; if (u_if.avs_readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%h exp=0", u_if.avs_readdata); end
    total++; if (u_if.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL reset_waitreq got=%b exp=1", u_if.avs_waitrequest); end
    reset = 1'b0;
    step();
    total++; if (dut.r_mon_a !== 8'h00) begin bad++; $display("FAIL reset_mona got=%h exp=00", dut.r_mon_a); end
  endtask

  task automatic test_load_addr();
    pulse(0, mk_a(1'b0, 8'h10));
    total++; if (dut.r_mon_a !== 8'h10) begin bad++; $display("FAIL load_mona got=%h exp=10", dut.r_mon_a); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL load_ready got=%b exp=1", monitor_ready); end
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL load_error got=%b exp=0", monitor_error); end
  endtask

  task automatic test_jtag_write_read();
    pulse(2, mk_b(32'hCAFEF00D));
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL wr_busy got=%b exp=0", monitor_ready); end
    step();
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL wr_done got=%b exp=1", monitor_ready); end
    total++; if (dut.r_mon_a !== 8'h11) begin bad++; $display("FAIL wr_mona got=%h exp=11", dut.r_mon_a); end
    pulse(0, mk_a(1'b1, 8'h10));
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL rd_busy1 got=%b exp=0", monitor_ready); end
    step();
    total++; if (monitor_ready !== 1'b0) begin bad++; $display("FAIL rd_busy2 got=%b exp=0", monitor_ready); end
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL rd_early got=%h exp=0", MonDReg); end
    step();
    total++; if (MonDReg !== 32'hCAFEF00D) begin bad++; $display("FAIL rd_data got=%h exp=cafef00d", MonDReg); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL rd_done got=%b exp=1", monitor_ready); end
    total++; if (dut.r_mon_a !== 8'h11) begin bad++; $display("FAIL rd_mona got=%h exp=11", dut.r_mon_a); end
    // write at 0x11, reload 0x11, read via no_action
    pulse(2, mk_b(32'h11111111)); step();
    pulse(0, mk_a(1'b0, 8'h11));
    pulse(1, '0); step(); step();
    total++; if (MonDReg !== 32'h11111111) begin bad++; $display("FAIL na_data got=%h exp=11111111", MonDReg); end
    total++; if (dut.r_mon_a !== 8'h12) begin bad++; $display("FAIL na_mona got=%h exp=12", dut.r_mon_a); end
  endtask

  task automatic test_range_error();
    pulse(0, mk_a(1'b0, 8'd250));
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL oor_load_error got=%b exp=1", monitor_error); end
    pulse(1, '0); step(); step();
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL oor_read got=%h exp=0", MonDReg); end
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL oor_read_error got=%b exp=1", monitor_error); end
    total++; if (dut.r_mon_a !== 8'd251) begin bad++; $display("FAIL oor_mona got=%h exp=fb", dut.r_mon_a); end
    pulse(0, mk_a(1'b0, 8'd5));
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL oor_clear got=%b exp=0", monitor_error); end
  endtask

  task automatic test_wrap_and_drop();
    pulse(0, mk_a(1'b0, 8'hFF));
    pulse(2, mk_b(32'hAAAA5555)); step();
    total++; if (dut.r_mon_a !== 8'h00) begin bad++; $display("FAIL wrap_mona got=%h exp=00", dut.r_mon_a); end
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL wrap_error got=%b exp=1", monitor_error); end
    pulse(0, mk_a(1'b0, 8'h20));
    total++; if (monitor_error !== 1'b0) begin bad++; $display("FAIL drop_pre got=%b exp=0", monitor_error); end
    // b held for two edges: second one lands in JWR and is dropped
    jdo = mk_b(32'h20202020); pb = 1'b1;
    step(); step();
    pb = 1'b0;
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL drop_error got=%b exp=1", monitor_error); end
    total++; if (dut.r_mon_a !== 8'h21) begin bad++; $display("FAIL drop_mona got=%h exp=21", dut.r_mon_a); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL drop_ready got=%b exp=1", monitor_ready); end
    // a and b together: b executes at current address, a is dropped
    pulse(0, mk_a(1'b0, 8'h30));
    jdo = mk_b(32'h30303030); jdo[24:17] = 8'h40; pa = 1'b1; pb = 1'b1;
    step();
    pa = 1'b0; pb = 1'b0;
    step();
    total++; if (dut.r_mon_a !== 8'h31) begin bad++; $display("FAIL prio_mona got=%h exp=31", dut.r_mon_a); end
    total++; if (monitor_error !== 1'b1) begin bad++; $display("FAIL prio_error got=%b exp=1", monitor_error); end
  endtask

  task automatic test_cpu();
    int          cyc;
    logic [31:0] rd;
    cpu_xfer(1'b0, 1'b1, 8'd3, 32'h1234, cyc, rd);
    total++; if (cyc !== 1) begin bad++; $display("FAIL cpu_wr_lat got=%0d exp=1", cyc); end
    cpu_xfer(1'b1, 1'b0, 8'd3, 32'h0, cyc, rd);
    total++; if (cyc !== 3) begin bad++; $display("FAIL cpu_rd_lat got=%0d exp=3", cyc); end
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL cpu_rd_data got=%h exp=1234", rd); end
    total++; if (u_if.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL cpu_wait_one got=%b exp=1", u_if.avs_waitrequest); end
    cpu_xfer(1'b1, 1'b1, 8'd3, 32'hDEAD, cyc, rd);
    total++; if (cyc !== 3 || rd !== 32'h1234) begin bad++; $display("FAIL cpu_rd_wins got=%0d/%h exp=3/1234", cyc, rd); end
    cpu_xfer(1'b1, 1'b0, 8'd210, 32'h0, cyc, rd);
    total++; if (rd !== 32'h0) begin bad++; $display("FAIL cpu_oor got=%h exp=0", rd); end
    // JTAG write and CPU read in the same cycle
    pulse(0, mk_a(1'b0, 8'h50));
    u_if.avs_address = 8'd3; u_if.avs_read = 1'b1;
    jdo = mk_b(32'h5050BEEF); pb = 1'b1;
    step();
    pb = 1'b0;
    cyc = 1;
    while (u_if.avs_waitrequest && cyc < 20) begin step(); cyc++; end
    rd = u_if.avs_readdata;
    step();
    u_if.avs_read = 1'b0;
    total++; if (cyc !== 5) begin bad++; $display("FAIL contend_lat got=%0d exp=5", cyc); end
    total++; if (rd !== 32'h1234) begin bad++; $display("FAIL contend_data got=%h exp=1234", rd); end
    total++; if (dut.r_mon_a !== 8'h51) begin bad++; $display("FAIL contend_mona got=%h exp=51", dut.r_mon_a); end
    pulse(0, mk_a(1'b1, 8'h50)); step(); step();
    total++; if (MonDReg !== 32'h5050BEEF) begin bad++; $display("FAIL contend_jdata got=%h exp=5050beef", MonDReg); end
  endtask

  task automatic test_reset_midop();
    pulse(0, mk_a(1'b1, 8'h10)); step(); step();
    total++; if (MonDReg !== 32'hCAFEF00D) begin bad++; $display("FAIL pre_rst_data got=%h exp=cafef00d", MonDReg); end
    pulse(0, mk_a(1'b1, 8'h10)); step();
    reset = 1'b1;
    #1;
    total++; if (MonDReg !== 32'h0) begin bad++; $display("FAIL rst_mid_mondreg got=%h exp=0", MonDReg); end
    total++; if (monitor_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", monitor_ready); end
    total++; if (u_if.avs_waitrequest !== 1'b1) begin bad++; $display("FAIL rst_mid_waitreq got=%b exp=1", u_if.avs_waitrequest); end
    #2;
    reset = 1'b0;
    step(); step();
    total++; if (dut.r_mon_a !== 8'h00 || monitor_ready !== 1'b1) begin bad++; $display("FAIL rst_idle got=%h/%b exp=00/1", dut.r_mon_a, monitor_ready); end
    pulse(0, mk_a(1'b1, 8'h10)); step(); step();
    total++; if (MonDReg !== 32'hCAFEF00D) begin bad++; $display("FAIL rst_retain got=%h exp=cafef00d", MonDReg); end
  endtask

  initial begin
    jdo = '0; pa = 1'b0; pna = 1'b0; pb = 1'b0;
    u_if.avs_address = '0; u_if.avs_read = 1'b0; u_if.avs_write = 1'b0; u_if.avs_writedata = '0;
    test_reset();
    test_load_addr();
    test_jtag_write_read();
    test_range_error();
    test_wrap_and_drop();
    test_cpu();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dnn_accel_system_cpu_debug_ocimem.md
Name: dnn_accel_system_cpu_debug_ocimem

Overview:
- Sysclk-domain consumer of the debug slave's decoded JTAG commands (jdo, take_action_ocimem_a/b, take_no_action_ocimem_a).
- Executes JTAG debug-memory reads and writes on a private on-chip RAM, and also exposes that RAM to the CPU through an Avalon-MM slave.
- Returns MonDReg, monitor_ready and monitor_error back upstream to the debug slave, which shifts them out over JTAG.

Parameters:
ADDR_W, 8, word-address width; 2..16
DEPTH, 256, implemented RAM words; 1 <= DEPTH <= 2**ADDR_W

Ports:
- clk  in  1  system clock; all logic rises on clk
- reset  in  1  asynchronous, active-high reset
- jdo  in  38  decoded JTAG data register
- take_action_ocimem_a  in  1  1-cycle pulse: load address; jdo[35]=1 also starts a read
- take_no_action_ocimem_a  in  1  1-cycle pulse: read at current address
- take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at current address
- MonDReg  out  32  last JTAG read data
- monitor_ready  out  1  JTAG command complete / idle
- monitor_error  out  1  sticky error flag
- avs_address  in  ADDR_W  CPU word address
- avs_read  in  1  CPU read request
- avs_write  in  1  CPU write request
- avs_writedata  in  32  CPU write data
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  Avalon stall

Behaviour:
- Reset is asynchronous, active-high; one clock domain only.
- Reset values:
  - MonDReg=0, monitor_ready=1, monitor_error=0, avs_readdata=0, avs_waitrequest=1.
  - Internal address MonAReg=0; state=IDLE.
  - RAM contents are not reset.
- RAM: single port, synchronous read with 1-cycle latency, write on the clk edge.
- States: IDLE, JRD, JCAP, JWR, CRD, CCAP, CDONE, CWR.
- IDLE, JTAG pulse present (JTAG has priority over CPU):
  - ocimem_b: go to JWR; monitor_ready<=0.
  - ocimem_a:
    - MonAReg<=jdo[17+:ADDR_W].
    - monitor_error<=0 if the loaded address < DEPTH, else 1.
    - If jdo[35]=1: go to JRD, monitor_ready<=0. Otherwise stay in IDLE, monitor_ready stays 1.
  - no_action_ocimem_a: go to JRD; monitor_ready<=0.
- JWR (1 cycle):
  - If MonAReg<DEPTH: RAM[MonAReg]<=jdo[34:3] as registered at accept. Otherwise no write and monitor_error<=1.
  - MonAReg<=MonAReg+1 (mod 2**ADDR_W).
  - monitor_ready<=1; go to IDLE.
- JRD: present MonAReg to the RAM; go to JCAP.
- JCAP:
  - MonDReg<=RAM data, or 0 with monitor_error<=1 if MonAReg>=DEPTH.
  - MonAReg+1; monitor_ready<=1; go to IDLE.
- JTAG latency, from the pulse edge: write completes 2 edges later; read completes (data + ready) 3 edges later.
- IDLE, no JTAG pulse, avs_read=1: go to CRD. With avs_write=1 instead: go to CWR. If both are high, read wins.
- CPU path:
  - CRD -> CCAP -> CDONE.
  - CDONE: avs_readdata valid; 0 if address >= DEPTH.
  - CWR: RAM written if address < DEPTH.
  - avs_waitrequest=0 only in CDONE and CWR; 1 in all other states.
  - Address and data are captured at accept. The master holds them per Avalon rules.
  - CDONE and CWR return to IDLE.
- Simultaneous JTAG pulses: priority b > a > no_action_a. Dropped pulses set monitor_error.
- JTAG pulse while not in IDLE: pulse dropped; monitor_error<=1; the operation in flight completes normally.
- CPU request during a JTAG operation: avs_waitrequest stays 1 until served. The CPU is served only from IDLE with no JTAG pulse present.
- Address wrap: MonAReg at 2**ADDR_W-1 increments to 0.
- Reset mid-operation: the operation is abandoned, no partial write occurs, and all outputs return to reset values immediately (asynchronously).

Test Plan:
1. ocimem_a with jdo[17+:8]=0x10, jdo[35]=0 -> MonAReg=0x10, monitor_ready stays 1, monitor_error=0.
2. ocimem_b with jdo[34:3]=0xCAFEF00D, then ocimem_a (addr 0x10, jdo[35]=1) -> MonDReg=0xCAFEF00D 3 edges after the pulse; monitor_ready low in between; MonAReg=0x11.
3. With DEPTH=200: ocimem_a addr 250 -> monitor_error=1; following read -> MonDReg=0, error stays 1; next ocimem_a addr 5 -> error=0.
4. MonAReg=0xFF, ocimem_b -> write at 0xFF, MonAReg=0x00. A second pulse issued while in JWR is dropped and sets monitor_error=1.
5. avs_write 0x1234 @ 3, then avs_read @ 3 -> readdata=0x1234 with waitrequest low exactly one cycle (CDONE). An ocimem_b pulse in the same cycle as avs_read -> JTAG write first, CPU stalled 2 extra cycles.
6. Assert reset while in JCAP -> MonDReg=0, monitor_ready=1, avs_waitrequest=1 immediately; after release the state is IDLE and the prior write data is retained.
